// File: rtl/debug_gpio_conditioner.sv
// Debug GPIO conditioner: per-lane passthrough / pulse-stretch / toggle / off drive with rising-edge counters.
// Define DEBUG_GPIO_EDGE_COUNT_EN to build the edge counters; without it edge_cnt_o reads constant 0.

module debug_gpio_cond_lane #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gpio_i,
  input  logic [1:0]           mode_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 cnt_clr_i,
  output logic                 gpio_o,
  output logic [LEN_WIDTH-1:0] edge_cnt_o
);
  localparam logic [1:0] M_PASS    = 2'd0;
  localparam logic [1:0] M_STRETCH = 2'd1;
  localparam logic [1:0] M_TOGGLE  = 2'd2;
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;
  localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic                 in_q;
  logic [1:0]           mode_q;
  logic [0:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 rise;

  assign rise   = gpio_i & ~in_q;
  assign gpio_o = out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    // A mode switch drops whatever the old mode was doing; a same-cycle rise is ignored.
    if (mode_i != mode_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      out_d   = 1'b0;
    end else begin
      case (mode_q)
        M_PASS:   out_d = gpio_i;
        M_STRETCH: begin
          if (state_q == S_IDLE) begin
            if (rise) begin
              state_d = S_HOLD;
              cnt_d   = len_i;
              out_d   = 1'b1;
            end else begin
              out_d   = 1'b0;
            end
          end else if (rise) begin
            cnt_d = len_i;
            out_d = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
            out_d = 1'b1;
          end else if (gpio_i) begin
            out_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            out_d   = 1'b0;
          end
        end
        M_TOGGLE: if (rise) out_d = ~out_q;
        default:  out_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= 1'b0;
      mode_q  <= M_PASS;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      in_q    <= gpio_i;
      mode_q  <= mode_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

`ifdef DEBUG_GPIO_EDGE_COUNT_EN
  logic [LEN_WIDTH-1:0] edge_q;

  // Clear beats a simultaneous rise; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 edge_q <= '0;
    else if (cnt_clr_i)         edge_q <= '0;
    else if (rise && !(&edge_q)) edge_q <= edge_q + ONE;
  end

  assign edge_cnt_o = edge_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign edge_cnt_o     = '0;
`endif
endmodule

module debug_gpio_conditioner #(
  parameter int LEN_WIDTH = 16,
  parameter int NUM_LANES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_LANES-1:0]                gpio_in_i,
  input  logic [NUM_LANES-1:0][1:0]           mode_i,
  input  logic [NUM_LANES-1:0][LEN_WIDTH-1:0] stretch_len_i,
  input  logic                                cnt_clr_i,
  output logic [NUM_LANES-1:0]                gpio_out_o,
  output logic [NUM_LANES-1:0][LEN_WIDTH-1:0] edge_cnt_o
);
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    debug_gpio_cond_lane #(.LEN_WIDTH(LEN_WIDTH)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .gpio_i     (gpio_in_i[g]),
      .mode_i     (mode_i[g]),
      .len_i      (stretch_len_i[g]),
      .cnt_clr_i  (cnt_clr_i),
      .gpio_o     (gpio_out_o[g]),
      .edge_cnt_o (edge_cnt_o[g])
    );
  end
endmodule

// File: tb/tb_debug_gpio_conditioner.sv
// Randomized + directed bench for debug_gpio_conditioner against a time-based reference model.
module tb_debug_gpio_conditioner;
  localparam int NL = 4;
  localparam int LW = 8;
  localparam int CMAX = (1 << LW) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NL-1:0]          gpio_in = '0;
  logic [NL-1:0][1:0]     mode = '0;
  logic [NL-1:0][LW-1:0]  slen = '0;
  logic                   cnt_clr = 1'b0;
  logic [NL-1:0]          gpio_out;
  logic [NL-1:0][LW-1:0]  edge_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  debug_gpio_conditioner #(.LEN_WIDTH(LW), .NUM_LANES(NL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gpio_in_i     (gpio_in),
    .mode_i        (mode),
    .stretch_len_i (slen),
    .cnt_clr_i     (cnt_clr),
    .gpio_out_o    (gpio_out),
    .edge_cnt_o    (edge_cnt)
  );

  // Reference: stretch output is high while within STRETCH_LEN cycles of the last
  // acted-on rise, or while the input is still in the high run that rise started.
  logic       m_prev [NL];
  logic [1:0] m_mode [NL];
  int         m_rise [NL];
  int         m_len  [NL];
  int         m_run  [NL];
  int         m_tog  [NL];
  int         m_cnt  [NL];
  logic [NL-1:0] exp_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_prev[i] = 1'b0; m_mode[i] = 2'd0; m_rise[i] = -1; m_len[i] = 0;
      m_run[i] = -2; m_tog[i] = 0; m_cnt[i] = 0;
    end
    exp_out = '0;
  endtask

  task automatic model_step();
    for (int i = 0; i < NL; i++) begin
      logic r;
      r = gpio_in[i] & ~m_prev[i];
      if (r) m_run[i] = cyc;
      if (cnt_clr) m_cnt[i] = 0;
      else if (r && m_cnt[i] < CMAX) m_cnt[i]++;
      if (mode[i] != m_mode[i]) begin
        m_mode[i] = mode[i]; m_rise[i] = -1; m_tog[i] = 0; exp_out[i] = 1'b0;
      end else begin
        case (m_mode[i])
          2'd0: exp_out[i] = gpio_in[i];
          2'd1: begin
            if (r) begin m_rise[i] = cyc; m_len[i] = int'(slen[i]); end
            exp_out[i] = (m_rise[i] >= 0) &&
                         ((cyc <= m_rise[i] + m_len[i]) || (gpio_in[i] && m_run[i] == m_rise[i]));
          end
          2'd2: begin
            if (r) m_tog[i]++;
            exp_out[i] = m_tog[i][0];
          end
          default: exp_out[i] = 1'b0;
        endcase
      end
      m_prev[i] = gpio_in[i];
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("gpio_out", 32'(gpio_out), 32'(exp_out));
    for (int i = 0; i < NL; i++) begin
`ifdef DEBUG_GPIO_EDGE_COUNT_EN
      chk($sformatf("edge_cnt%0d", i), 32'(edge_cnt[i]), 32'(m_cnt[i]));
`else
      chk($sformatf("edge_cnt%0d", i), 32'(edge_cnt[i]), 32'd0);
`endif
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_all(input logic [1:0] md, input int len);
    for (int i = 0; i < NL; i++) begin
      mode[i] = md;
      slen[i] = LW'(len);
    end
  endtask

  int hi;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(gpio_out), 32'd0);
    chk("rst_cnt0", 32'(edge_cnt[0]), 32'd0);

    // Input already high at release counts as a rise.
    gpio_in = '1;
    rst_n   = 1'b1;
    tick();
    gpio_in = '0;
    repeat (2) tick();

    // 1-cycle pulse, stretch 5 -> 6 high cycles.
    set_all(2'd1, 5);
    repeat (3) tick();
    gpio_in = '1; tick();
    gpio_in = '0;
    hi = int'(gpio_out[0]);
    repeat (10) begin tick(); hi += int'(gpio_out[0]); end
    chk("stretch5_width", 32'(hi), 32'd6);

    // Retrigger: pulses 3 apart with stretch 4 -> 8 contiguous high cycles.
    set_all(2'd1, 4);
    gpio_in = '1; tick();
    gpio_in = '0; hi = int'(gpio_out[0]);
    tick(); hi += int'(gpio_out[0]);
    tick(); hi += int'(gpio_out[0]);
    gpio_in = '1; tick(); hi += int'(gpio_out[0]);
    gpio_in = '0;
    repeat (10) begin tick(); hi += int'(gpio_out[0]); end
    chk("retrig_width", 32'(hi), 32'd8);

    // Stretch 0 and a long input pulse; changing STRETCH_LEN mid-hold.
    set_all(2'd1, 0);
    gpio_in = '1; repeat (4) tick();
    gpio_in = '0; repeat (3) tick();
    set_all(2'd1, 3);
    gpio_in = '1; tick();
    gpio_in = '0; slen = '0; repeat (6) tick();

    // Toggle mode.
    set_all(2'd2, 0);
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      gpio_in = '1; tick();
      gpio_in = '0; repeat (3) tick();
    end

    // Stretch 50 interrupted by switch to passthrough.
    set_all(2'd1, 50);
    tick();
    gpio_in = '1; tick();
    gpio_in = '0; repeat (5) tick();
    set_all(2'd0, 50);
    for (int k = 0; k < 12; k++) begin gpio_in = NL'($urandom); tick(); end

    // Async reset in the middle of a long hold.
    gpio_in = '0;
    set_all(2'd1, 100);
    repeat (2) tick();
    gpio_in = '1; tick();
    gpio_in = '0; repeat (30) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(gpio_out), 32'd0);
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    repeat (8) tick();

    // Saturate the counters, then clear against a simultaneous rise.
    set_all(2'd2, 0);
    cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    for (int k = 0; k < CMAX + 3; k++) begin
      gpio_in = '1; tick();
      gpio_in = '0; tick();
    end
    gpio_in = '1; cnt_clr = 1'b1; tick();
    gpio_in = '0; cnt_clr = 1'b0; repeat (2) tick();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 2) == 0) gpio_in[i] = ~gpio_in[i];
        if ($urandom_range(0, 63) == 0) mode[i] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) slen[i] = LW'($urandom_range(0, 6));
      end
      cnt_clr = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
